// File: rtl/com_uart_rx.sv
// com_uart_rx: 8N1 serial receiver with a first-word fall-through byte FIFO.
// Raises a level interrupt while bytes are pending. Keeps sticky overrun
// and framing-error flags until they are cleared or the block is reset.
module com_uart_rx #(
    parameter int unsigned DIV   = 16,  // clocks per bit, even and >= 4
    parameter int unsigned DEPTH = 8    // FIFO entries, power of two
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] data_o,
    output logic       empty_o,
    output logic       int_o,
    output logic       overrun_o,
    output logic       frame_err_o
);

    localparam int unsigned TW = $clog2(DIV);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [TW-1:0] HALF_M1  = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(DIV - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic          r_sync1;
    logic          r_rxs;
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_frame_err;
    logic          r_overrun;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_stop_tick;
    logic w_push;
    logic w_fe_set;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;
    logic w_ovr_set;

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxs   <= r_sync1;
        end
    end

    // The push lands on the same edge that ends the stop-sample cycle, so
    // the stop decision is taken combinationally from the FSM state here.
    assign w_stop_tick = (r_state == S_STOP) && (r_timer == FULL_M1);
    assign w_push      = w_stop_tick && r_rxs;
    assign w_fe_set    = w_stop_tick && !r_rxs;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_FULL);
    assign w_pop     = rd_en && !w_empty;
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovr_set = w_push && w_full && !w_pop;

    // Receive FSM: start detect, mid-bit sampling, LSB-first shift, stop check
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (!r_rxs) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_timer == HALF_M1) begin
                        r_timer <= '0;
                        if (!r_rxs) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DATA: begin
                    if (r_timer == FULL_M1) begin
                        r_timer <= '0;
                        r_shift <= {r_rxs, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_STOP: begin
                    if (r_timer == FULL_M1) begin
                        r_timer <= '0;
                        r_state <= r_rxs ? S_IDLE : S_BREAK;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_BREAK: begin
                    r_timer <= '0;
                    if (r_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    // Sticky error flags; a new error in the clear cycle wins over the clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_fe_set) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // FIFO storage and pointers; a pop frees the slot for a same-cycle push
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_o      = r_mem[r_rd_ptr];
    assign empty_o     = w_empty;
    assign int_o       = !w_empty;
    assign overrun_o   = r_overrun;
    assign frame_err_o = r_frame_err;

endmodule

// File: tb/tb_com_uart_rx.sv
// Directed testbench for com_uart_rx at DIV=16, DEPTH=8.
// Line changes and strobes are driven at the falling clock edge and
// outputs are sampled at falling edges.
module tb_com_uart_rx;

    localparam int unsigned DIV = 16;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] data_o;
    logic       empty_o;
    logic       int_o;
    logic       overrun_o;
    logic       frame_err_o;

    int n_cmp;
    int n_err;

    com_uart_rx #(
        .DIV   (16),
        .DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .rd_en       (rd_en),
        .err_clr     (err_clr),
        .data_o      (data_o),
        .empty_o     (empty_o),
        .int_o       (int_o),
        .overrun_o   (overrun_o),
        .frame_err_o (frame_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start bit plus 8 data bits; returns at the negedge where the stop bit begins
    task automatic drive_bits(input logic [7:0] b);
        rxd = 1'b0;
        wait_neg(DIV);
        for (int k = 0; k < 8; k++) begin
            rxd = b[k];
            wait_neg(DIV);
        end
    endtask

    task automatic send_frame(input logic [7:0] b);
        drive_bits(b);
        rxd = 1'b1;
        wait_neg(DIV);
    endtask

    task automatic pop_one;
        rd_en = 1'b1;
        wait_neg(1);
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; rxd = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        wait_neg(3);
        n_cmp++;
        if ({empty_o, int_o, overrun_o, frame_err_o, data_o} !== {4'b1000, 8'h00}) begin
            n_err++;
            $display("FAIL reset_outputs: got e=%b i=%b o=%b f=%b d=%h, want e=1 i=0 o=0 f=0 d=00",
                     empty_o, int_o, overrun_o, frame_err_o, data_o);
        end
        rst = 1'b1;
        wait_neg(4);
    endtask

    // Frame 0xA5 with exact output timing; line edge at cycle c, stop sample c+154
    task automatic test_frame_timing;
        drive_bits(8'hA5);
        rxd = 1'b1;
        wait_neg(10);
        n_cmp++;
        if (empty_o !== 1'b1) begin
            n_err++;
            $display("FAIL timing_early: empty_o=%b in stop-sample cycle, want 1", empty_o);
        end
        wait_neg(1);
        n_cmp++;
        if (int_o !== 1'b1 || empty_o !== 1'b0) begin
            n_err++;
            $display("FAIL timing_int: int_o=%b empty_o=%b, want 1/0", int_o, empty_o);
        end
        n_cmp++;
        if (data_o !== 8'hA5) begin
            n_err++;
            $display("FAIL timing_data: data_o=%h, want a5", data_o);
        end
        wait_neg(5);
        pop_one();
        n_cmp++;
        if (empty_o !== 1'b1 || int_o !== 1'b0) begin
            n_err++;
            $display("FAIL pop_last: empty_o=%b int_o=%b, want 1/0", empty_o, int_o);
        end
    endtask

    // Short low glitch is rejected; rd_en on an empty FIFO is ignored
    task automatic test_glitch;
        rxd = 1'b0;
        wait_neg(5);
        rxd = 1'b1;
        wait_neg(30);
        n_cmp++;
        if ({empty_o, overrun_o, frame_err_o} !== 3'b100) begin
            n_err++;
            $display("FAIL glitch: e=%b o=%b f=%b, want 1 0 0", empty_o, overrun_o, frame_err_o);
        end
        pop_one();
        pop_one();
        send_frame(8'h6E);
        n_cmp++;
        if (data_o !== 8'h6E || empty_o !== 1'b0) begin
            n_err++;
            $display("FAIL empty_pop_ignored: data_o=%h empty_o=%b, want 6e/0", data_o, empty_o);
        end
        pop_one();
        n_cmp++;
        if (empty_o !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_drain: empty_o=%b, want 1", empty_o);
        end
    endtask

    // Bad stop bit with err_clr in the same cycle (set wins), then clear, then good frame
    task automatic test_frame_err;
        drive_bits(8'h3C);
        rxd = 1'b0;
        wait_neg(10);
        err_clr = 1'b1;
        wait_neg(1);
        err_clr = 1'b0;
        n_cmp++;
        if (frame_err_o !== 1'b1) begin
            n_err++;
            $display("FAIL frame_err_set_wins: frame_err_o=%b, want 1", frame_err_o);
        end
        wait_neg(5);
        rxd = 1'b1;
        wait_neg(10);
        n_cmp++;
        if (frame_err_o !== 1'b1 || empty_o !== 1'b1) begin
            n_err++;
            $display("FAIL frame_err_hold: frame_err_o=%b empty_o=%b, want 1/1", frame_err_o, empty_o);
        end
        err_clr = 1'b1;
        wait_neg(1);
        err_clr = 1'b0;
        n_cmp++;
        if (frame_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL frame_err_clear: frame_err_o=%b, want 0", frame_err_o);
        end
        send_frame(8'h11);
        n_cmp++;
        if (data_o !== 8'h11 || empty_o !== 1'b0 || frame_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL after_frame_err: data_o=%h empty_o=%b frame_err_o=%b, want 11/0/0",
                     data_o, empty_o, frame_err_o);
        end
        pop_one();
    endtask

    // Nine back-to-back frames without reads: ninth is dropped with overrun
    task automatic test_overrun;
        for (int i = 0; i < 9; i++) begin
            send_frame(8'(i));
        end
        n_cmp++;
        if (overrun_o !== 1'b1 || empty_o !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_set: overrun_o=%b empty_o=%b, want 1/0", overrun_o, empty_o);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (data_o !== 8'(i) || empty_o !== 1'b0) begin
                n_err++;
                $display("FAIL overrun_read[%0d]: data_o=%h empty_o=%b, want %h/0", i, data_o, empty_o, 8'(i));
            end
            pop_one();
        end
        n_cmp++;
        if (empty_o !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_drain: empty_o=%b, want 1", empty_o);
        end
        err_clr = 1'b1;
        wait_neg(1);
        err_clr = 1'b0;
        n_cmp++;
        if (overrun_o !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_clear: overrun_o=%b, want 0", overrun_o);
        end
    endtask

    // Full FIFO, pop in the push cycle of 0x99: no overrun, 0x99 read last
    task automatic test_full_push_pop;
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) begin
            send_frame(8'h20 + 8'(i));
        end
        drive_bits(8'h99);
        rxd = 1'b1;
        wait_neg(10);
        rd_en = 1'b1;
        wait_neg(1);
        rd_en = 1'b0;
        wait_neg(5);
        n_cmp++;
        if (overrun_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_pushpop_overrun: overrun_o=%b, want 0", overrun_o);
        end
        for (int i = 0; i < 8; i++) begin
            exp = (i == 7) ? 8'h99 : 8'h21 + 8'(i);
            n_cmp++;
            if (data_o !== exp || empty_o !== 1'b0) begin
                n_err++;
                $display("FAIL full_read[%0d]: data_o=%h empty_o=%b, want %h/0", i, data_o, empty_o, exp);
            end
            pop_one();
        end
        n_cmp++;
        if (empty_o !== 1'b1) begin
            n_err++;
            $display("FAIL full_drain: empty_o=%b, want 1", empty_o);
        end
    endtask

    // Asynchronous reset during data bit 4 with a pending byte and a set flag
    task automatic test_mid_frame_reset;
        send_frame(8'h77);
        drive_bits(8'h3C);
        rxd = 1'b0;
        wait_neg(12);
        err_clr = 1'b0;
        wait_neg(10);
        n_cmp++;
        if (frame_err_o !== 1'b1 || data_o !== 8'h77 || int_o !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_state: frame_err_o=%b data_o=%h int_o=%b, want 1/77/1",
                     frame_err_o, data_o, int_o);
        end
        rxd = 1'b1;
        wait_neg(4);
        // frame 0xC3: start + bits 0..3, then into the middle of bit 4
        rxd = 1'b0;
        wait_neg(DIV);
        for (int k = 0; k < 4; k++) begin
            rxd = (8'hC3 >> k) & 8'h01;
            wait_neg(DIV);
        end
        rxd = 1'b0;
        wait_neg(8);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({empty_o, int_o, overrun_o, frame_err_o, data_o} !== {4'b1000, 8'h00}) begin
            n_err++;
            $display("FAIL midframe_reset: e=%b i=%b o=%b f=%b d=%h, want 1 0 0 0 00",
                     empty_o, int_o, overrun_o, frame_err_o, data_o);
        end
        rxd = 1'b1;
        wait_neg(3);
        rst = 1'b1;
        wait_neg(DIV * 8);
        n_cmp++;
        if (empty_o !== 1'b1 || frame_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL after_release: empty_o=%b frame_err_o=%b, want 1/0", empty_o, frame_err_o);
        end
        send_frame(8'h5A);
        n_cmp++;
        if (data_o !== 8'h5A || empty_o !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_frame: data_o=%h empty_o=%b, want 5a/0", data_o, empty_o);
        end
        pop_one();
        n_cmp++;
        if (empty_o !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_drain: empty_o=%b, want 1", empty_o);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_frame_timing();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_push_pop();
        test_mid_frame_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
